// File: rtl/mem_responder_if.sv
// CPU-side memory request/response bundle shared by the cpu and mem_responder.
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder: latches a request, answers with a one-cycle mem_resp LATENCY cycles later.
// Initiator holds the request until mem_resp; dropping it early aborts the transaction and sets protocol_err.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  mem_responder_if.slave mem,
  output logic [31:0] read_count,
  output logic [31:0] write_count,
  output logic        protocol_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int         DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                  state;
  logic [3:0]              cnt;
  logic                    op_write;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [3:0]              be;
  logic [31:0]             wdata;
  logic [31:0]             mem_array [DEPTH];

  logic [ADDR_WIDTH-1:0]   req_idx;
  logic                    req_any;
  logic                    unused_addr;

  assign req_idx     = mem.mem_address[ADDR_WIDTH+1:2];
  assign req_any     = mem.mem_read | mem.mem_write;
  assign unused_addr = ^{mem.mem_address[31:ADDR_WIDTH+2], mem.mem_address[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      op_write      <= 1'b0;
      idx           <= '0;
      be            <= 4'd0;
      wdata         <= 32'd0;
      mem.mem_resp  <= 1'b0;
      mem.mem_rdata <= 32'd0;
      read_count    <= 32'd0;
      write_count   <= 32'd0;
      protocol_err  <= 1'b0;
    end else begin
      mem.mem_resp <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            op_write <= mem.mem_write;
            idx      <= req_idx;
            be       <= mem.mem_byte_enable;
            wdata    <= mem.mem_wdata;
            cnt      <= LAT_M1;
            if (mem.mem_read && mem.mem_write) protocol_err <= 1'b1;
            if (LATENCY > 1) begin
              state <= S_WAIT;
            end else begin
              // Single-cycle latency: array is read with the live index
              state        <= S_RESP;
              mem.mem_resp <= 1'b1;
              if (!mem.mem_write) mem.mem_rdata <= mem_array[req_idx];
            end
          end
        end
        S_WAIT: begin
          if (!req_any) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            protocol_err <= 1'b1;
          end else if (cnt <= 4'd1) begin
            state        <= S_RESP;
            cnt          <= 4'd0;
            mem.mem_resp <= 1'b1;
            if (!op_write) mem.mem_rdata <= mem_array[idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          if (op_write) write_count <= write_count + 32'd1;
          else          read_count  <= read_count + 32'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write commits on the edge leaving RESP; a reset before then loses it
  always_ff @(posedge clk) begin
    if (rst && state == S_RESP && op_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_array[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=3 main instance plus a LATENCY=1 instance for spacing.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] rc3, wc3, rc1, wc1;
  logic        err3, err1;
  int          n_tests;
  int          n_fail;
  int          lat;
  int          seen;
  logic [31:0] rdat;

  mem_responder_if bus3();
  mem_responder_if bus1();

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst_n), .mem(bus3),
    .read_count(rc3), .write_count(wc3), .protocol_err(err3)
  );

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst_n), .mem(bus1),
    .read_count(rc1), .write_count(wc1), .protocol_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on the LATENCY=3 bus, hold it until mem_resp, return cycles-to-resp.
  task automatic txn3(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      output int l, output logic [31:0] d);
    bus3.mem_read        = rd;
    bus3.mem_write       = wr;
    bus3.mem_address     = addr;
    bus3.mem_wdata       = wd;
    bus3.mem_byte_enable = be;
    l = -1;
    d = 'x;
    for (int i = 1; i <= 20 && l < 0; i++) begin
      @(posedge clk); #1;
      if (bus3.mem_resp) begin
        l = i;
        d = bus3.mem_rdata;
      end
    end
    bus3.mem_read  = 1'b0;
    bus3.mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus3.mem_read = 1'b0; bus3.mem_write = 1'b0; bus3.mem_byte_enable = 4'h0;
    bus3.mem_address = 32'd0; bus3.mem_wdata = 32'd0;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.mem_byte_enable = 4'h0;
    bus1.mem_address = 32'd0; bus1.mem_wdata = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp",  {31'd0, bus3.mem_resp}, 32'd0);
    chk("rst_rdata", bus3.mem_rdata, 32'd0);
    chk("rst_rc",    rc3, 32'd0);
    chk("rst_wc",    wc3, 32'd0);
    chk("rst_err",   {31'd0, err3}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write then read
    txn3(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, lat, rdat);
    chk("w1_lat", lat, 3);
    txn3(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, rdat);
    chk("r1_lat", lat, 3);
    chk("r1_data", rdat, 32'hDEAD_BEEF);
    chk("r1_rc", rc3, 32'd1);
    chk("r1_wc", wc3, 32'd1);

    // Byte lanes
    txn3(1'b0, 1'b1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, lat, rdat);
    txn3(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, rdat);
    chk("be1_data", rdat, 32'hDEAD_BEAA);
    txn3(1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, lat, rdat);
    chk("be0_lat", lat, 3);
    txn3(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, rdat);
    chk("be0_data", rdat, 32'hDEAD_BEAA);
    chk("be_wc", wc3, 32'd3);
    chk("be_rc", rc3, 32'd3);

    // Address aliasing and ignored low bits
    txn3(1'b0, 1'b1, 32'h0000_1004, 32'h1111_1111, 4'hF, lat, rdat);
    txn3(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0, lat, rdat);
    chk("alias_data", rdat, 32'h1111_1111);
    txn3(1'b1, 1'b0, 32'h0000_0007, 32'h0, 4'h0, lat, rdat);
    chk("lowbits_data", rdat, 32'h1111_1111);
    chk("alias_rc", rc3, 32'd5);
    chk("pre_err", {31'd0, err3}, 32'd0);

    // Read and write together: serviced as a write, flagged
    txn3(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0005, 4'hF, lat, rdat);
    chk("both_lat", lat, 3);
    chk("both_err", {31'd0, err3}, 32'd1);
    chk("both_wc", wc3, 32'd5);
    chk("both_rc", rc3, 32'd5);
    txn3(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, lat, rdat);
    chk("both_rdback", rdat, 32'h0000_0005);

    // Read dropped while waiting
    bus3.mem_read = 1'b1; bus3.mem_address = 32'h0000_0010;
    @(posedge clk); #1;
    bus3.mem_read = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus3.mem_resp) seen++;
    end
    chk("abort_no_resp", seen, 0);
    chk("abort_rc", rc3, 32'd6);
    chk("abort_err", {31'd0, err3}, 32'd1);

    // Reset during the wait of a write
    txn3(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 4'hF, lat, rdat);
    bus3.mem_write = 1'b1; bus3.mem_address = 32'h0000_0040;
    bus3.mem_wdata = 32'h1234_5678; bus3.mem_byte_enable = 4'hF;
    @(posedge clk); #1;
    seen = 0;
    if (bus3.mem_resp) seen++;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wc", wc3, 32'd0);
    chk("mid_rst_rc", rc3, 32'd0);
    chk("mid_rst_err", {31'd0, err3}, 32'd0);
    @(posedge clk); #1;
    if (bus3.mem_resp) seen++;
    bus3.mem_write = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus3.mem_resp) seen++;
    end
    chk("mid_rst_no_resp", seen, 0);
    txn3(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, lat, rdat);
    chk("mid_rst_rdback", rdat, 32'h0000_0000);
    chk("mid_rst_rc_after", rc3, 32'd1);
    chk("mid_rst_wc_after", wc3, 32'd0);

    // LATENCY=1 instance: write/read then a held read
    bus1.mem_write = 1'b1; bus1.mem_address = 32'h0000_0008;
    bus1.mem_wdata = 32'hCAFE_F00D; bus1.mem_byte_enable = 4'hF;
    @(posedge clk); #1;
    chk("l1_w_resp", {31'd0, bus1.mem_resp}, 32'd1);
    bus1.mem_write = 1'b0;
    @(posedge clk); #1;
    bus1.mem_read = 1'b1;
    @(posedge clk); #1;
    chk("l1_r_resp", {31'd0, bus1.mem_resp}, 32'd1);
    chk("l1_r_data", bus1.mem_rdata, 32'hCAFE_F00D);
    bus1.mem_read = 1'b0;
    @(posedge clk); #1;
    chk("l1_wc", wc1, 32'd1);
    chk("l1_rc", rc1, 32'd1);
    bus1.mem_read = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("l1_held_resp_c%0d", i), {31'd0, bus1.mem_resp}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    chk("l1_held_data", bus1.mem_rdata, 32'hCAFE_F00D);
    bus1.mem_read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("l1_held_rc", rc1, 32'd4);
    chk("l1_err", {31'd0, err1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
